// File: rtl/instr_issuer_if.sv
// instr_issuer_if: program-sequencer bus bundling the ROM port, the
// run/din/done issue handshake and the status outputs.
// master = the issuer, slave = the ROM/control-unit/status side.
interface instr_issuer_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [15:0]       din;
  logic              run;
  logic              done;
  logic              busy;
  logic              halted;
  logic              error;
  logic [7:0]        instr_count;

  modport master (
    input  start, rom_data, done,
    output rom_addr, din, run, busy, halted, error, instr_count
  );

  modport slave (
    output start, rom_data, done,
    input  rom_addr, din, run, busy, halted, error, instr_count
  );
endinterface

// File: rtl/instr_issuer.sv
// instr_issuer: fetches 16-bit words from a synchronous program ROM,
// issues each to the control unit with a one-cycle active-low run strobe,
// waits for done, then advances. A word with opcode 3'b111 ends the program.
// Optional done watchdog: define ISSUER_TIMEOUT_EN.
module instr_issuer #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32,
  parameter int TIMEOUT  = 8
) (
  input  logic           clk,
  input  logic           reset,
  instr_issuer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_DONE, HALT
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       din_q;
  logic              run_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic              busy_c, halted_c;
  logic              start_acc;
  logic              last_pc;
  logic              is_marker;
  logic              wd_fire;

  if (PROG_LEN < 1 || PROG_LEN > (2 ** ADDR_W) || TIMEOUT < 1) begin : g_bad_param
    $error("instr_issuer: PROG_LEN must be 1..2**ADDR_W and TIMEOUT >= 1");
  end

  assign start_acc = ((state == IDLE) || (state == HALT)) && bus.start;
  assign last_pc   = (pc == ADDR_W'(PROG_LEN - 1));
  assign is_marker = (bus.rom_data[15:13] == 3'b111);

`ifdef ISSUER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state == WAIT_DONE) && !bus.done && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Watchdog counter: cleared outside WAIT_DONE, counts cycles without done
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wd_cnt <= '0;
    else if (state != WAIT_DONE) wd_cnt <= '0;
    else if (!bus.done)         wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky error flag, cleared only by an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          err_q <= 1'b0;
    else if (start_acc) err_q <= 1'b0;
    else if (wd_fire)   err_q <= 1'b1;
  end
`else
  assign wd_fire = 1'b0;
  assign err_q   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, HALT: if (bus.start) state_nx = FETCH;
      FETCH:      state_nx = WAIT_ROM;
      WAIT_ROM:   state_nx = is_marker ? HALT : ISSUE;
      ISSUE:      state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.done)     state_nx = last_pc ? HALT : FETCH;
        else if (wd_fire) state_nx = HALT;
      end
      default:    state_nx = IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy_c   = 1'b0;
    halted_c = 1'b0;
    unique case (state)
      FETCH, WAIT_ROM, ISSUE, WAIT_DONE: busy_c = 1'b1;
      HALT:                              halted_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: pc, captured instruction, completion count, registered run strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      din_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else begin
      run_q <= (state_nx != ISSUE);
      if (start_acc) begin
        pc    <= '0;
        cnt_q <= '0;
      end else if (state == WAIT_DONE && bus.done) begin
        cnt_q <= cnt_q + 1'b1;
        if (!last_pc) pc <= pc + 1'b1;
      end
      if (state == WAIT_ROM && !is_marker) din_q <= bus.rom_data;
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.din         = din_q;
  assign bus.run         = run_q;
  assign bus.busy        = busy_c;
  assign bus.halted      = halted_c;
  assign bus.error       = err_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: table-driven program scenarios plus hand-written
// sequences for restart, start-ignore, asynchronous reset and the watchdog.
module tb_instr_issuer;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done_en = 1'b1;
  always #5 clk = ~clk;

  instr_issuer_if #(.ADDR_W(AW)) ifm ();
  instr_issuer_if #(.ADDR_W(AW)) if1 ();

  instr_issuer #(.ADDR_W(AW), .PROG_LEN(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bus(ifm.master)
  );
  instr_issuer #(.ADDR_W(AW), .PROG_LEN(1), .TIMEOUT(8)) dut_one (
    .clk(clk), .reset(reset), .bus(if1.master)
  );

  // synchronous program ROM shared by both instances
  logic [15:0] rom [32];
  always @(posedge clk) begin
    ifm.rom_data <= rom[ifm.rom_addr];
    if1.rom_data <= rom[if1.rom_addr];
  end

  // control-unit model: done in WAIT_DONE cycle 2 (MV/MVT) or 4 (ADD/SUB)
  function automatic int unsigned lat_of(input logic [15:0] w);
    return (w[15:13] == 3'b000 || w[15:13] == 3'b001) ? 2 : 4;
  endfunction

  int unsigned wcnt_m, wcnt_1;
  always @(posedge clk) begin
    if (reset || !done_en) begin
      wcnt_m <= 0; ifm.done <= 1'b0;
    end else if (!ifm.run) begin
      wcnt_m <= lat_of(ifm.din) - 1; ifm.done <= 1'b0;
    end else if (wcnt_m != 0) begin
      wcnt_m <= wcnt_m - 1; ifm.done <= (wcnt_m == 1);
    end else ifm.done <= 1'b0;
  end
  always @(posedge clk) begin
    if (reset || !done_en) begin
      wcnt_1 <= 0; if1.done <= 1'b0;
    end else if (!if1.run) begin
      wcnt_1 <= lat_of(if1.din) - 1; if1.done <= 1'b0;
    end else if (wcnt_1 != 0) begin
      wcnt_1 <= wcnt_1 - 1; if1.done <= (wcnt_1 == 1);
    end else if1.done <= 1'b0;
  end

  // monitor on the falling edge: issue times/addresses, start and halt times
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int unsigned n_iss = 0;
  int unsigned t_iss [256];
  logic [AW-1:0] a_iss [256];
  int unsigned t_start = 0, t_halt = 0;
  logic prev_halt = 1'b0;
  always @(negedge clk) begin
    if (!ifm.run) begin
      t_iss[n_iss[7:0]] <= cyc;
      a_iss[n_iss[7:0]] <= ifm.rom_addr;
      n_iss <= n_iss + 1;
    end
    if (ifm.start) t_start <= cyc;
    if (ifm.halted && !prev_halt) t_halt <= cyc;
    prev_halt <= ifm.halted;
  end

  int n_pass = 0, n_tot = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    ifm.start = 1'b1; if1.start = 1'b1;
    tick();
    ifm.start = 1'b0; if1.start = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned bound, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < bound; i++)
      if (!ok) begin
        if (ifm.halted) ok = 1'b1;
        else tick();
      end
  endtask

  task automatic wait_issue(input int unsigned target, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < 50; i++)
      if (!ok) begin
        if (n_iss >= target) ok = 1'b1;
        else tick();
      end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, 32'(ifm.rom_addr), 0);
    check({tag, "_din"}, 32'(ifm.din), 0);
    check({tag, "_run"}, 32'(ifm.run), 1);
    check({tag, "_busy"}, 32'(ifm.busy), 0);
    check({tag, "_halted"}, 32'(ifm.halted), 0);
    check({tag, "_error"}, 32'(ifm.error), 0);
    check({tag, "_count"}, 32'(ifm.instr_count), 0);
  endtask

  task automatic load(input logic [3:0][15:0] p);
    for (int a = 0; a < 32; a++) rom[a] = 16'h0000;
    for (int a = 0; a < 4; a++) rom[a] = p[a];
  endtask

  typedef struct packed {
    logic [3:0][15:0] prog;
    logic [3:0]       n;
    logic [3:0][3:0]  gap;
    logic [3:0]       hl;
    logic [15:0]      din;
    logic [7:0]       cnt;
    logic [4:0]       addr;
  } vec_t;

  vec_t vecs [5];
  logic [3:0][15:0] p0;
  int unsigned base, ref_t;
  bit ok, err_seen, busy_low;

  initial begin
    ifm.start = 1'b0; if1.start = 1'b0;
    for (int a = 0; a < 32; a++) rom[a] = 16'h0000;
    //            prog (word3..word0)                          n   gaps(3..0)         hl  din       cnt   addr
    vecs[0] = '{prog:{16'h0A07,16'h6401,16'h4203,16'h1205}, n:4, gap:{4'd7,4'd7,4'd5,4'd3}, hl:3, din:16'h0A07, cnt:4, addr:3};
    vecs[1] = '{prog:{16'h0000,16'h0000,16'hE000,16'h1205}, n:1, gap:{4'd0,4'd0,4'd0,4'd3}, hl:5, din:16'h1205, cnt:1, addr:1};
    vecs[2] = '{prog:{16'h1234,16'hE000,16'h4A05,16'h2100}, n:2, gap:{4'd0,4'd0,4'd5,4'd3}, hl:7, din:16'h4A05, cnt:2, addr:2};
    vecs[3] = '{prog:{16'h0000,16'h0000,16'h0000,16'hF123}, n:0, gap:{4'd0,4'd0,4'd0,4'd0}, hl:3, din:16'h0000, cnt:0, addr:0};
    vecs[4] = '{prog:{16'h1FFF,16'h4000,16'h2FFF,16'h6000}, n:4, gap:{4'd7,4'd5,4'd7,4'd3}, hl:3, din:16'h1FFF, cnt:4, addr:3};

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].prog);
      do_reset();
      if (v == 0) check_reset_vals("reset");
      base = n_iss;
      pulse_start();
      wait_halt(200, ok);
      check($sformatf("v%0d_halt_reached", v), 32'(ok), 1);
      tick();
      check($sformatf("v%0d_issues", v), n_iss - base, 32'(vecs[v].n));
      for (int i = 0; i < 4; i++)
        if (i < int'(vecs[v].n)) begin
          ref_t = (i == 0) ? t_start : t_iss[8'(base + i - 1)];
          check($sformatf("v%0d_gap%0d", v, i), t_iss[8'(base + i)] - ref_t, 32'(vecs[v].gap[i]));
          check($sformatf("v%0d_addr%0d", v, i), 32'(a_iss[8'(base + i)]), i);
        end
      ref_t = (vecs[v].n == 0) ? t_start : t_iss[8'(base + vecs[v].n - 1)];
      check($sformatf("v%0d_halt_lat", v), t_halt - ref_t, 32'(vecs[v].hl));
      check($sformatf("v%0d_din", v), 32'(ifm.din), 32'(vecs[v].din));
      check($sformatf("v%0d_count", v), 32'(ifm.instr_count), 32'(vecs[v].cnt));
      check($sformatf("v%0d_rom_addr", v), 32'(ifm.rom_addr), 32'(vecs[v].addr));
      check($sformatf("v%0d_halted", v), 32'(ifm.halted), 1);
      check($sformatf("v%0d_busy", v), 32'(ifm.busy), 0);
      check($sformatf("v%0d_run", v), 32'(ifm.run), 1);
      p0 = vecs[v].prog;
      check($sformatf("v%0d_one_halted", v), 32'(if1.halted), 1);
      check($sformatf("v%0d_one_count", v), 32'(if1.instr_count), (p0[0][15:13] == 3'b111) ? 0 : 1);
      check($sformatf("v%0d_one_din", v), 32'(if1.din), (p0[0][15:13] == 3'b111) ? 0 : 32'(p0[0]));
      check($sformatf("v%0d_one_addr", v), 32'(if1.rom_addr), 0);
    end

    // start during WAIT_DONE is ignored; start in HALT restarts from pc 0
    load(vecs[0].prog);
    do_reset();
    base = n_iss;
    pulse_start();
    wait_issue(base + 1, ok);
    check("ign_first_issue", 32'(ok), 1);
    pulse_start();
    wait_halt(200, ok);
    check("ign_halt_reached", 32'(ok), 1);
    tick();
    check("ign_issues", n_iss - base, 4);
    check("ign_count", 32'(ifm.instr_count), 4);
    base = n_iss;
    pulse_start();
    check("restart_count_clr", 32'(ifm.instr_count), 0);
    check("restart_rom_addr", 32'(ifm.rom_addr), 0);
    check("restart_busy", 32'(ifm.busy), 1);
    check("restart_halted", 32'(ifm.halted), 0);
    wait_halt(200, ok);
    tick();
    check("restart_issues", n_iss - base, 4);
    check("restart_count", 32'(ifm.instr_count), 4);

    // asynchronous reset during the second instruction's WAIT_DONE
    load(vecs[4].prog);
    do_reset();
    base = n_iss;
    pulse_start();
    wait_issue(base + 2, ok);
    check("rst_second_issue", 32'(ok), 1);
    check("rst_pre_count", 32'(ifm.instr_count), 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    tick();
    reset = 1'b0;
    base = n_iss;
    pulse_start();
    wait_halt(200, ok);
    tick();
    check("post_rst_issues", n_iss - base, 4);
    check("post_rst_count", 32'(ifm.instr_count), 4);

    // done withheld
    done_en = 1'b0;
    load(vecs[0].prog);
    do_reset();
    base = n_iss;
    pulse_start();
`ifdef ISSUER_TIMEOUT_EN
    wait_halt(50, ok);
    check("wd_halt_reached", 32'(ok), 1);
    tick();
    check("wd_error", 32'(ifm.error), 1);
    check("wd_halted", 32'(ifm.halted), 1);
    check("wd_latency", t_halt - t_iss[8'(base)], 9);
    check("wd_issues", n_iss - base, 1);
    done_en = 1'b1;
    pulse_start();
    check("wd_error_clr", 32'(ifm.error), 0);
    wait_halt(200, ok);
    check("wd_rerun_error", 32'(ifm.error), 0);
    check("wd_rerun_count", 32'(ifm.instr_count), 4);
`else
    err_seen = 1'b0;
    busy_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifm.error) err_seen = 1'b1;
      if (!ifm.busy) busy_low = 1'b1;
    end
    check("nowd_error_seen", 32'(err_seen), 0);
    check("nowd_busy_dropped", 32'(busy_low), 0);
    check("nowd_issues", n_iss - base, 1);
    check("nowd_count", 32'(ifm.instr_count), 0);
    done_en = 1'b1;
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
